fifo_read_ctrl: RTL and testbench

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_read_ctrl_if.sv | 36 +++
 rtl/ptr_sync.sv | 30 +++
 rtl/fifo_read_ctrl.sv | 103 ++++++++++
 tb/tb_fifo_read_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer code conversions and default widths, used by both
// the read-side and write-side controllers.
package fifo_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAddrWidth = 4;

  // Binary to Gray; callers truncate the result to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary; upper bits beyond the caller's pointer width must be zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = '0;
    for (int i = 0; i < 32; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// RAM read port plus output stream handshake of the FIFO read controller.
interface fifo_read_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
);

  logic                  read_en;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;

  // Controller side.
  modport master (
    output read_en,
    output read_addr,
    input  ram_data,
    output data_out,
    output data_valid,
    input  data_ready
  );

  // RAM and consumer side.
  modport slave (
    input  read_en,
    input  read_addr,
    output ram_data,
    input  data_out,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
module ptr_sync #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  // Shift the pointer through the synchronizer chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of an async FIFO: synchronizes the write pointer, issues
// RAM reads with one-cycle latency and buffers words in a 2-entry skid FIFO so
// the stream sustains one word per clock under a ready/valid handshake.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_read,
  input  logic                rst_n,
  input  logic [ADDR_WIDTH:0] wr_ptr_gray,
  output logic [ADDR_WIDTH:0] rd_ptr_gray,
  output logic                empty,
  output logic [ADDR_WIDTH:0] occupancy,
  fifo_read_ctrl_if.master    bus
);

  localparam int unsigned PtrWidth = ADDR_WIDTH + 1;

  logic [PtrWidth-1:0]   wq_ptr_gray;
  logic [PtrWidth-1:0]   rd_ptr_bin_q;
  logic [PtrWidth-1:0]   rd_ptr_bin_d;
  logic [PtrWidth-1:0]   rd_ptr_gray_q;
  logic                  inflight_q;
  logic [1:0]            buf_count_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  pop;
  logic [2:0]            demand;

  ptr_sync #(
    .WIDTH       (PtrWidth),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wr_ptr_sync (
    .clk_i  (clk_read),
    .rst_ni (rst_n),
    .d_i    (wr_ptr_gray),
    .q_o    (wq_ptr_gray)
  );

  // Status, stream head and read-issue decision.
  always_comb begin
    empty          = (rd_ptr_gray_q == wq_ptr_gray);
    occupancy      = PtrWidth'(gray2bin(32'(wq_ptr_gray))) - rd_ptr_bin_q;
    bus.data_valid = (buf_count_q != 2'd0);
    bus.data_out   = buf_q[0];
    pop            = bus.data_valid & bus.data_ready;
    // Words buffered or in flight after this cycle's pop; keep it below the buffer depth.
    demand         = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};
    bus.read_en    = !empty && (demand < 3'd2);
    bus.read_addr  = rd_ptr_bin_q[ADDR_WIDTH-1:0];
    rd_ptr_bin_d   = rd_ptr_bin_q + PtrWidth'(1);
  end

  assign rd_ptr_gray = rd_ptr_gray_q;

  // Advance the read pointer on each issued read; track the RAM latency slot.
  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_bin_q  <= '0;
      rd_ptr_gray_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      inflight_q <= bus.read_en;
      if (bus.read_en) begin
        rd_ptr_bin_q  <= rd_ptr_bin_d;
        rd_ptr_gray_q <= PtrWidth'(bin2gray(32'(rd_ptr_bin_d)));
      end
    end
  end

  // Two-entry output FIFO; entry 0 is always the head.
  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) begin
      buf_count_q <= 2'd0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
    end else begin
      case ({inflight_q, pop})
        2'b10: begin
          if (buf_count_q == 2'd0) buf_q[0] <= bus.ram_data;
          else                     buf_q[1] <= bus.ram_data;
          buf_count_q <= buf_count_q + 2'd1;
        end
        2'b01: begin
          buf_q[0]    <= buf_q[1];
          buf_count_q <= buf_count_q - 2'd1;
        end
        2'b11: begin
          if (buf_count_q == 2'd1) begin
            buf_q[0] <= bus.ram_data;
          end else begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= bus.ram_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: write side and RAM are modelled here.
module tb_fifo_read_ctrl;
  import fifo_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   wr_bin = '0;
  logic [AW:0]   wr_ptr_gray;
  logic [AW:0]   rd_ptr_gray;
  logic [AW:0]   occupancy;
  logic          empty;
  logic [DW-1:0] ram [16];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_read_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_read_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (2)
  ) dut (
    .clk_read    (clk),
    .rst_n       (rst_n),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .empty       (empty),
    .occupancy   (occupancy),
    .bus         (bus)
  );

  assign wr_ptr_gray = 5'(bin2gray(32'(wr_bin)));

  // One-cycle-latency RAM read port.
  always @(posedge clk) begin
    if (bus.read_en) bus.ram_data <= ram[bus.read_addr];
  end

  // Monitor: samples on the falling edge, away from the active edge.
  int            cyc = 0;
  int            re_cnt = 0;
  int            bad_re = 0;
  int            gray_err = 0;
  logic [AW-1:0] addr_q[$];
  int            re_cyc_q[$];
  logic [DW-1:0] got_q[$];
  int            pop_cyc_q[$];
  logic [AW:0]   gray_prev = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.read_en) begin
        re_cnt++;
        addr_q.push_back(bus.read_addr);
        re_cyc_q.push_back(cyc);
        if (empty) bad_re++;
      end
      if (bus.data_valid && bus.data_ready) begin
        got_q.push_back(bus.data_out);
        pop_cyc_q.push_back(cyc);
      end
      if (rd_ptr_gray != gray_prev && $countones(rd_ptr_gray ^ gray_prev) != 1) gray_err++;
    end
    gray_prev = rst_n ? rd_ptr_gray : '0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    re_cnt = 0;
    addr_q.delete();
    re_cyc_q.delete();
    got_q.delete();
    pop_cyc_q.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.data_ready = 1'b0;
    wr_bin = '0;
    cycles(2);
    clear_mon();
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 'x;
  endfunction

  initial begin
    int written;
    int errs;
    int guard;

    bus.data_ready = 1'b0;

    // Reset state with a pending write pointer of 2.
    rst_n = 1'b0;
    wr_bin = 5'd2;
    ram[0] = 8'h55;
    ram[1] = 8'h66;
    cycles(3);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_occ", 32'(occupancy), 32'd0);
    check_eq("rst_valid", 32'(bus.data_valid), 32'd0);
    check_eq("rst_read_en", 32'(bus.read_en), 32'd0);
    check_eq("rst_rd_gray", 32'(rd_ptr_gray), 32'd0);
    check_eq("rst_data_out", 32'(bus.data_out), 32'd0);
    check_eq("rst_read_addr", 32'(bus.read_addr), 32'd0);
    clear_mon();
    rst_n = 1'b1;
    cycles(1);
    check_eq("rel_empty_edge1", 32'(empty), 32'd1);
    cycles(1);
    check_eq("rel_empty_edge2", 32'(empty), 32'd0);
    check_eq("rel_occ_edge2", 32'(occupancy), 32'd2);
    bus.data_ready = 1'b1;
    cycles(8);
    check_eq("rel_words", 32'(got_q.size()), 32'd2);
    check_eq("rel_word0", 32'(got_at(0)), 32'h55);
    check_eq("rel_word1", 32'(got_at(1)), 32'h66);

    // Single word.
    do_reset();
    ram[0] = 8'hA5;
    bus.data_ready = 1'b1;
    wr_bin = 5'd1;
    cycles(10);
    check_eq("single_re_cnt", 32'(re_cnt), 32'd1);
    check_eq("single_addr", (addr_q.size() > 0) ? 32'(addr_q[0]) : 32'hx, 32'd0);
    check_eq("single_words", 32'(got_q.size()), 32'd1);
    check_eq("single_data", 32'(got_at(0)), 32'hA5);
    check_eq("single_latency",
             (re_cyc_q.size() > 0 && pop_cyc_q.size() > 0) ? 32'(pop_cyc_q[0] - re_cyc_q[0])
                                                           : 32'hx, 32'd2);
    check_eq("single_rd_gray", 32'(rd_ptr_gray), 32'b00001);
    check_eq("single_empty", 32'(empty), 32'd1);
    check_eq("single_valid", 32'(bus.data_valid), 32'd0);

    // Backpressure.
    do_reset();
    for (int i = 0; i < 4; i++) ram[i] = 8'(8'h10 + i);
    wr_bin = 5'd4;
    cycles(10);
    check_eq("bp_re_cnt", 32'(re_cnt), 32'd2);
    check_eq("bp_valid", 32'(bus.data_valid), 32'd1);
    check_eq("bp_head", 32'(bus.data_out), 32'h10);
    cycles(5);
    check_eq("bp_hold", 32'(bus.data_out), 32'h10);
    check_eq("bp_re_hold", 32'(re_cnt), 32'd2);
    bus.data_ready = 1'b1;
    cycles(10);
    check_eq("bp_words", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("bp_order", 32'(got_at(i)), 32'(8'h10 + i));
    check_eq("bp_b2b", (pop_cyc_q.size() == 4) ? 32'(pop_cyc_q[3] - pop_cyc_q[0]) : 32'hx, 32'd3);
    check_eq("bp_re_total", 32'(re_cnt), 32'd4);

    // Wrap: 40 words streamed with the consumer always ready.
    do_reset();
    bus.data_ready = 1'b1;
    written = 0;
    guard = 0;
    while (written < 40 && guard < 500) begin
      cycles(1);
      guard++;
      if (written - got_q.size() < 16) begin
        ram[wr_bin[3:0]] = 8'(written * 7 + 3);
        wr_bin = wr_bin + 5'd1;
        written++;
      end
    end
    check_eq("wrap_feed_done", 32'(written), 32'd40);
    cycles(20);
    check_eq("wrap_words", 32'(got_q.size()), 32'd40);
    errs = 0;
    for (int i = 0; i < 40; i++) if (got_at(i) !== 8'(i * 7 + 3)) errs++;
    check_eq("wrap_data_errs", 32'(errs), 32'd0);
    check_eq("wrap_rd_gray", 32'(rd_ptr_gray), 32'b01100);
    check_eq("wrap_addr15", (addr_q.size() > 16) ? 32'(addr_q[15]) : 32'hx, 32'd15);
    check_eq("wrap_addr16", (addr_q.size() > 16) ? 32'(addr_q[16]) : 32'hx, 32'd0);
    check_eq("wrap_empty", 32'(empty), 32'd1);

    // Full occupancy.
    do_reset();
    for (int i = 0; i < 16; i++) ram[i] = 8'(8'hC0 + i);
    wr_bin = 5'd16;
    cycles(2);
    check_eq("full_occ", 32'(occupancy), 32'd16);
    check_eq("full_empty", 32'(empty), 32'd0);
    cycles(10);
    bus.data_ready = 1'b1;
    cycles(30);
    check_eq("full_drain_occ", 32'(occupancy), 32'd0);
    check_eq("full_drain_empty", 32'(empty), 32'd1);
    check_eq("full_words", 32'(got_q.size()), 32'd16);
    check_eq("full_last", 32'(got_at(15)), 32'hCF);

    // Reset mid-stream with words buffered and one in flight.
    do_reset();
    for (int i = 0; i < 8; i++) ram[i] = 8'(8'h20 + i);
    wr_bin = 5'd8;
    cycles(10);
    check_eq("mid_pre_valid", 32'(bus.data_valid), 32'd1);
    check_eq("mid_pre_head", 32'(bus.data_out), 32'h20);
    bus.data_ready = 1'b1;
    cycles(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_valid", 32'(bus.data_valid), 32'd0);
    check_eq("mid_read_en", 32'(bus.read_en), 32'd0);
    check_eq("mid_empty", 32'(empty), 32'd1);
    check_eq("mid_occ", 32'(occupancy), 32'd0);
    check_eq("mid_data_out", 32'(bus.data_out), 32'd0);
    check_eq("mid_pre_words", 32'(got_q.size()), 32'd1);
    wr_bin = '0;
    cycles(2);
    clear_mon();
    rst_n = 1'b1;
    cycles(10);
    check_eq("mid_post_words", 32'(got_q.size()), 32'd0);
    check_eq("mid_post_re", 32'(re_cnt), 32'd0);
    check_eq("mid_post_valid", 32'(bus.data_valid), 32'd0);

    check_eq("never_read_when_empty", 32'(bad_re), 32'd0);
    check_eq("gray_one_bit_steps", 32'(gray_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
